// File: rtl/div_seq.sv
// Radix-2 restoring divider for DIV/DIVU, one quotient bit per clock.
// Holds busy_o while iterating and presents {remainder, quotient} until start_i drops.
module div_seq #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o,
    output logic                  busy_o
);

    typedef enum logic [1:0] {
        FREE   = 2'b00,
        BYZERO = 2'b01,
        ON     = 2'b10,
        END    = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W);

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   divisor;
    logic [DATA_W-1:0]   dividend;   // shifts out dividend bits, shifts in quotient bits
    logic [DATA_W-1:0]   partial;
    logic                sign1;
    logic                sign2;
    logic                signed_op;

    logic [DATA_W:0]     shifted;
    logic [DATA_W:0]     diff;
    logic [DATA_W-1:0]   abs1;
    logic [DATA_W-1:0]   abs2;
    logic [DATA_W-1:0]   quot_fix;
    logic [DATA_W-1:0]   rem_fix;

    // partial < divisor always holds, so the top bit of diff is a clean borrow flag.
    assign shifted  = {partial, dividend[DATA_W-1]};
    assign diff     = shifted - {1'b0, divisor};

    assign abs1     = (signed_div_i && opdata1_i[DATA_W-1]) ? (~opdata1_i + 1'b1) : opdata1_i;
    assign abs2     = (signed_div_i && opdata2_i[DATA_W-1]) ? (~opdata2_i + 1'b1) : opdata2_i;

    assign quot_fix = (signed_op && (sign1 ^ sign2)) ? (~dividend + 1'b1) : dividend;
    assign rem_fix  = (signed_op && sign1) ? (~partial + 1'b1) : partial;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= FREE;
            cnt       <= '0;
            divisor   <= '0;
            dividend  <= '0;
            partial   <= '0;
            sign1     <= 1'b0;
            sign2     <= 1'b0;
            signed_op <= 1'b0;
            result_o  <= '0;
            ready_o   <= 1'b0;
            busy_o    <= 1'b0;
        end else begin
            case (state)
                FREE: begin
                    ready_o  <= 1'b0;
                    result_o <= '0;
                    if (start_i && !annul_i) begin
                        busy_o <= 1'b1;
                        if (opdata2_i == '0) begin
                            state <= BYZERO;
                        end else begin
                            state     <= ON;
                            cnt       <= '0;
                            partial   <= '0;
                            dividend  <= abs1;
                            divisor   <= abs2;
                            signed_op <= signed_div_i;
                            sign1     <= signed_div_i & opdata1_i[DATA_W-1];
                            sign2     <= signed_div_i & opdata2_i[DATA_W-1];
                        end
                    end else begin
                        busy_o <= 1'b0;
                    end
                end

                BYZERO: begin
                    busy_o <= 1'b0;
                    if (annul_i) begin
                        state <= FREE;
                    end else begin
                        state    <= END;
                        result_o <= '0;
                        ready_o  <= 1'b1;
                    end
                end

                ON: begin
                    if (annul_i) begin
                        state  <= FREE;
                        cnt    <= '0;
                        busy_o <= 1'b0;
                    end else if (cnt < LAST_CNT) begin
                        partial  <= diff[DATA_W] ? shifted[DATA_W-1:0] : diff[DATA_W-1:0];
                        dividend <= {dividend[DATA_W-2:0], ~diff[DATA_W]};
                        cnt      <= cnt + 1'b1;
                    end else begin
                        result_o <= {rem_fix, quot_fix};
                        ready_o  <= 1'b1;
                        busy_o   <= 1'b0;
                        state    <= END;
                    end
                end

                END: begin
                    busy_o <= 1'b0;
                    if (!start_i) begin
                        state    <= FREE;
                        ready_o  <= 1'b0;
                        result_o <= '0;
                        cnt      <= '0;
                    end
                end

                default: begin
                    state    <= FREE;
                    ready_o  <= 1'b0;
                    busy_o   <= 1'b0;
                    result_o <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: table of divides plus annul and reset sequences.
module tb_div_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        busy_o;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    div_seq #(.DATA_W(32), .CNT_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .busy_o       (busy_o)
    );

    typedef struct {
        string       name;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          lat;
        int          busy_cyc;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drives one divide with start held, scrambles operands after accept,
    // checks latency, busy width, result, END hold (with annul) and release.
    task automatic run_div(input vec_t v);
        int edges = 0;
        int busy_n = 0;
        logic junk = 1'b0;
        logic [63:0] held;
        @(negedge clk);
        signed_div_i = v.sgn;
        opdata1_i    = v.a;
        opdata2_i    = v.b;
        start_i      = 1'b1;
        annul_i      = 1'b0;
        while (edges < 100) begin
            @(negedge clk);
            edges++;
            if (edges == 1) begin
                opdata1_i = ~v.a;
                opdata2_i = v.b ^ 32'h0000_0005;
            end
            if (busy_o) busy_n++;
            if (!ready_o && result_o != 64'd0) junk = 1'b1;
            if (ready_o) break;
        end
        check({v.name, " latency"}, 64'(edges), 64'(v.lat));
        check({v.name, " busy cycles"}, 64'(busy_n), 64'(v.busy_cyc));
        check({v.name, " result"}, result_o, v.exp);
        check({v.name, " result zero before ready"}, {63'd0, junk}, 64'd0);
        held    = result_o;
        annul_i = 1'b1;
        @(negedge clk);
        check({v.name, " END hold"}, {ready_o, busy_o, result_o}, {1'b1, 1'b0, held});
        annul_i = 1'b0;
        start_i = 1'b0;
        @(negedge clk);
        check({v.name, " release"}, {ready_o, busy_o, result_o}, 66'd0);
    endtask

    initial begin
        vecs.push_back('{"divu 100/7",  1'b0, 32'd100,       32'd7,         {32'h2, 32'hE},                   34, 33});
        vecs.push_back('{"div -7/2",    1'b1, 32'hFFFF_FFF9, 32'h2,         {32'hFFFF_FFFF, 32'hFFFF_FFFD},   34, 33});
        vecs.push_back('{"div 7/-2",    1'b1, 32'h7,         32'hFFFF_FFFE, {32'h1, 32'hFFFF_FFFD},           34, 33});
        vecs.push_back('{"div ovf",     1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000},           34, 33});
        vecs.push_back('{"divu max/1",  1'b0, 32'hFFFF_FFFF, 32'h1,         {32'h0, 32'hFFFF_FFFF},           34, 33});
        vecs.push_back('{"divu max/7",  1'b0, 32'hFFFF_FFFF, 32'h7,         {32'h3, 32'h2492_4924},           34, 33});
        vecs.push_back('{"div -9/-4",   1'b1, 32'hFFFF_FFF7, 32'hFFFF_FFFC, {32'hFFFF_FFFF, 32'h2},           34, 33});
        vecs.push_back('{"divu by0",    1'b0, 32'd55,        32'd0,         64'd0,                            2,  1});
        vecs.push_back('{"div by0",     1'b1, 32'hFFFF_FF00, 32'd0,         64'd0,                            2,  1});

        rst = 1'b0; start_i = 1'b0; annul_i = 1'b0;
        signed_div_i = 1'b0; opdata1_i = '0; opdata2_i = '0;
        repeat (3) @(negedge clk);
        check("reset outputs", {ready_o, busy_o, result_o}, 66'd0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) run_div(vecs[i]);

        // start with annul in FREE must not accept
        start_i = 1'b1; annul_i = 1'b1; opdata1_i = 32'd9; opdata2_i = 32'd3;
        repeat (3) @(negedge clk);
        check("start+annul no accept", {63'd0, busy_o}, 64'd0);
        start_i = 1'b0; annul_i = 1'b0;
        @(negedge clk);

        // annul sampled on edge 10 of a divide
        begin
            logic saw_ready = 1'b0;
            start_i = 1'b1; signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7;
            repeat (9) @(negedge clk);
            check("busy before annul", {63'd0, busy_o}, 64'd1);
            annul_i = 1'b1;
            @(negedge clk);
            start_i = 1'b0; annul_i = 1'b0;
            check("annul to FREE", {ready_o, busy_o, result_o}, 66'd0);
            repeat (40) begin
                @(negedge clk);
                if (ready_o || busy_o) saw_ready = 1'b1;
            end
            check("no ready after annul", {63'd0, saw_ready}, 64'd0);
        end
        run_div('{"divu 9/3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 34, 33});

        // reset asserted on edge 20 of a divide
        start_i = 1'b1; signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3;
        repeat (19) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mid-op reset", {ready_o, busy_o, result_o}, 66'd0);
        start_i = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("idle after reset", {ready_o, busy_o, result_o}, 66'd0);
        run_div('{"divu 15/4", 1'b0, 32'd15, 32'd4, {32'd3, 32'd3}, 34, 33});

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
